// File: rtl/ps2_key_tracker.sv
// PS/2 frame assembler with E0/F0 prefix decoding and held-key bitmaps for two players.
// Optional macro PS2_PARITY_CHECK_EN turns on odd-parity enforcement at the stop bit.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keyb_clk_db,
    input  logic       kdata_db,
    output logic [4:0] p1keys,
    output logic [4:0] p2keys,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_break,
    output logic       code_ext,
    output logic       frame_err
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction

    function automatic logic [4:0] p1_mask(input logic [7:0] sc);
        case (sc)
            8'h75:   p1_mask = 5'b00001;
            8'h6B:   p1_mask = 5'b00010;
            8'h74:   p1_mask = 5'b00100;
            8'h72:   p1_mask = 5'b01000;
            8'h29:   p1_mask = 5'b10000;
            default: p1_mask = 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] p2_mask(input logic [7:0] sc);
        case (sc)
            8'h1D:   p2_mask = 5'b00001;
            8'h1C:   p2_mask = 5'b00010;
            8'h1B:   p2_mask = 5'b00100;
            8'h23:   p2_mask = 5'b01000;
            8'h0D:   p2_mask = 5'b10000;
            default: p2_mask = 5'b00000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        keyb_clk_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [4:0]  p1keys_q, p1keys_d;
    logic [4:0]  p2keys_q, p2keys_d;
    logic        code_valid_q, code_valid_d;
    logic [7:0]  code_q, code_d;
    logic        code_break_q, code_break_d;
    logic        code_ext_q, code_ext_d;
    logic        frame_err_q, frame_err_d;

    logic        fall_s;
    logic        err_s;
    logic        accept_s;
    logic        par_ok_s;

    assign fall_s = keyb_clk_q & ~keyb_clk_db;

    // Parity verdict for the byte currently sitting in STOP.
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        par_ok_s = odd_parity_ok(shift_q, par_q);
`else
        // Parity is still captured so the datapath matches; its verdict is overridden.
        par_ok_s = odd_parity_ok(shift_q, par_q) | 1'b1;
`endif
    end

    // Frame FSM next state, bit shifter and inter-edge timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        err_s     = 1'b0;
        accept_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    if (!kdata_db) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_d   = {kdata_db, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    par_d   = kdata_db;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    state_d = ST_IDLE;
                    if (kdata_db && par_ok_s) begin
                        accept_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An edge on the limit cycle takes priority over the timeout.
        if (fall_s) begin
            cnt_d = 16'd0;
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == TIMEOUT_LIMIT) begin
                cnt_d   = 16'd0;
                err_s   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Prefix tracking, code reporting and key bitmap update.
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        p1keys_d     = p1keys_q;
        p2keys_d     = p2keys_q;
        code_d       = code_q;
        code_break_d = code_break_q;
        code_ext_d   = code_ext_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (err_s) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (accept_s) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_d       = shift_q;
                code_break_d = brk_q;
                code_ext_d   = ext_q;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                if (brk_q) begin
                    p1keys_d = p1keys_q & ~p1_mask(shift_q);
                    p2keys_d = p2keys_q & ~p2_mask(shift_q);
                end else begin
                    p1keys_d = p1keys_q | p1_mask(shift_q);
                    p2keys_d = p2keys_q | p2_mask(shift_q);
                end
            end
        end else begin
            frame_err_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            keyb_clk_q   <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            cnt_q        <= 16'd0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            p1keys_q     <= 5'd0;
            p2keys_q     <= 5'd0;
            code_valid_q <= 1'b0;
            code_q       <= 8'd0;
            code_break_q <= 1'b0;
            code_ext_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            keyb_clk_q   <= keyb_clk_db;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            cnt_q        <= cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            p1keys_q     <= p1keys_d;
            p2keys_q     <= p2keys_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            code_break_q <= code_break_d;
            code_ext_q   <= code_ext_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign p1keys     = p1keys_q;
    assign p2keys     = p2keys_q;
    assign code_valid = code_valid_q;
    assign code       = code_q;
    assign code_break = code_break_q;
    assign code_ext   = code_ext_q;
    assign frame_err  = frame_err_q;

endmodule
